// File: rtl/clock_pkg.sv
// Shared widths and BCD wrap limits for the time-of-day counter.
package clock_pkg;

    localparam int ONES_W    = 4;
    localparam int MS_TENS_W = 3;
    localparam int HR_TENS_W = 2;

    localparam int SEC_W = ONES_W + MS_TENS_W;
    localparam int MIN_W = ONES_W + MS_TENS_W;
    localparam int HR_W  = ONES_W + HR_TENS_W;

    localparam logic [SEC_W-1:0] SEC_MAX   = 7'h59;
    localparam logic [MIN_W-1:0] MIN_MAX   = 7'h59;
    localparam logic [HR_W-1:0]  HR_MAX_24 = 6'h23;
    localparam logic [HR_W-1:0]  HR_MAX_12 = 6'h12;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_e;

endpackage

// File: rtl/bcd_counter.sv
// Two-digit packed-BCD counter: wraps from i_wrap_val to i_base_val and flags the wrap on o_carry.
module bcd_counter #(
    parameter int                  TENS_W  = 3,
    parameter logic [TENS_W+3:0]   RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_inc,
    input  logic              i_clr,
    input  logic [TENS_W+3:0] i_wrap_val,
    input  logic [TENS_W+3:0] i_base_val,
    output logic [TENS_W+3:0] o_value,
    output logic              o_carry
);
    import clock_pkg::*;

    localparam logic [TENS_W-1:0] TENS_ONE = 1;

    logic [TENS_W+3:0] r_value;
    logic [TENS_W+3:0] w_next;
    logic [3:0]        w_ones;
    logic [TENS_W-1:0] w_tens;
    logic [TENS_W-1:0] w_max_tens;
    logic [TENS_W-1:0] w_tens_next;

    assign w_ones     = r_value[3:0];
    assign w_tens     = r_value[TENS_W+3:4];
    assign w_max_tens = i_wrap_val[TENS_W+3:4];

    // Out-of-range digits fold back to zero instead of sticking in an invalid code.
    always_comb begin
        w_tens_next = (w_tens >= w_max_tens) ? '0 : w_tens + TENS_ONE;
        w_next      = r_value;
        if (r_value == i_wrap_val) begin
            w_next = i_base_val;
        end else if (w_ones >= 4'd9) begin
            w_next = {w_tens_next, 4'd0};
        end else begin
            w_next = {w_tens, w_ones + 4'd1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value <= RST_VAL;
        end else if (i_clr) begin
            r_value <= '0;
        end else if (i_inc) begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;
    assign o_carry = i_inc && (r_value == i_wrap_val);

endmodule

// File: rtl/clock_register.sv
// Time-of-day counter fed by clock_divider ticks and set buttons; BCD hh:mm:ss out.
// Define CLOCK_REGISTER_12HR_EN for 12-hour counting with a pm output.
module clock_register
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_1hz,
    input  logic             clk_set,
    input  logic             set_hours,
    input  logic             set_minutes,
    output logic [HR_W-1:0]  hours,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
`ifdef CLOCK_REGISTER_12HR_EN
    output logic             pm,
`endif
    output logic             sec_tick
);

`ifdef CLOCK_REGISTER_12HR_EN
    localparam logic [HR_W-1:0] HR_WRAP = HR_MAX_12;
    localparam logic [HR_W-1:0] HR_BASE = 6'h01;
    localparam logic [HR_W-1:0] HR_RST  = 6'h12;
`else
    localparam logic [HR_W-1:0] HR_WRAP = HR_MAX_24;
    localparam logic [HR_W-1:0] HR_BASE = 6'h00;
    localparam logic [HR_W-1:0] HR_RST  = 6'h00;
`endif

    logic [SYNC_STAGES-1:0] r_sync_h;
    logic [SYNC_STAGES-1:0] r_sync_m;
    logic                   r_prev_1hz;
    logic                   r_prev_set;
    logic                   r_sec_tick;

    logic  w_sh, w_sm, w_tick_1hz, w_tick_set;
    logic  w_sec_inc, w_min_inc, w_hr_inc;
    logic  w_sec_carry, w_min_carry, w_hr_carry;
    mode_e w_mode;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync_h   <= '0;
            r_sync_m   <= '0;
            r_prev_1hz <= 1'b0;
            r_prev_set <= 1'b0;
        end else begin
            r_sync_h   <= {r_sync_h[SYNC_STAGES-2:0], set_hours};
            r_sync_m   <= {r_sync_m[SYNC_STAGES-2:0], set_minutes};
            r_prev_1hz <= clk_1hz;
            r_prev_set <= clk_set;
        end
    end

    assign w_sh       = r_sync_h[SYNC_STAGES-1];
    assign w_sm       = r_sync_m[SYNC_STAGES-1];
    assign w_tick_1hz = clk_1hz & ~r_prev_1hz;
    assign w_tick_set = clk_set & ~r_prev_set;
    assign w_mode     = (w_sh | w_sm) ? MODE_SET : MODE_RUN;

    // Setting never ripples carries between fields; each button drives its own field.
    assign w_sec_inc = (w_mode == MODE_RUN) && w_tick_1hz;
    assign w_min_inc = (w_mode == MODE_RUN) ? w_sec_carry : (w_tick_set && w_sm);
    assign w_hr_inc  = (w_mode == MODE_RUN) ? w_min_carry : (w_tick_set && w_sh);

    bcd_counter #(.TENS_W(MS_TENS_W), .RST_VAL(7'h00)) u_sec (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_inc      (w_sec_inc),
        .i_clr      (w_mode == MODE_SET),
        .i_wrap_val (SEC_MAX),
        .i_base_val (7'h00),
        .o_value    (seconds),
        .o_carry    (w_sec_carry)
    );

    bcd_counter #(.TENS_W(MS_TENS_W), .RST_VAL(7'h00)) u_min (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_inc      (w_min_inc),
        .i_clr      (1'b0),
        .i_wrap_val (MIN_MAX),
        .i_base_val (7'h00),
        .o_value    (minutes),
        .o_carry    (w_min_carry)
    );

    bcd_counter #(.TENS_W(HR_TENS_W), .RST_VAL(HR_RST)) u_hr (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_inc      (w_hr_inc),
        .i_clr      (1'b0),
        .i_wrap_val (HR_WRAP),
        .i_base_val (HR_BASE),
        .o_value    (hours),
        .o_carry    (w_hr_carry)
    );

    // Any increment always changes its field, so the pulse only needs the enables.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sec_tick <= 1'b0;
        end else begin
            r_sec_tick <= w_sec_inc | w_min_inc | w_hr_inc
                        | ((w_mode == MODE_SET) && (seconds != '0));
        end
    end

    assign sec_tick = r_sec_tick;

`ifdef CLOCK_REGISTER_12HR_EN
    logic r_pm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pm <= 1'b0;
        end else if (w_hr_inc && (hours == 6'h11)) begin
            r_pm <= ~r_pm;
        end
    end

    assign pm = r_pm;
`endif

    logic w_unused;
    assign w_unused = w_hr_carry;

endmodule

// File: tb/tb_clock_register.sv
// Directed bench for clock_register; CLOCK_REGISTER_12HR_EN selects the 12-hour checks.
module tb_clock_register;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clk_1hz = 1'b0;
    logic       clk_set = 1'b0;
    logic       set_hours = 1'b0;
    logic       set_minutes = 1'b0;
    logic [5:0] hours;
    logic [6:0] minutes;
    logic [6:0] seconds;
    logic       sec_tick;
`ifdef CLOCK_REGISTER_12HR_EN
    logic       pm;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    clock_register #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clk_1hz     (clk_1hz),
        .clk_set     (clk_set),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .hours       (hours),
        .minutes     (minutes),
        .seconds     (seconds),
`ifdef CLOCK_REGISTER_12HR_EN
        .pm          (pm),
`endif
        .sec_tick    (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input logic [5:0] h, input logic [6:0] m,
                              input logic [6:0] s);
        check({tag, ".hours"}, {26'd0, hours}, {26'd0, h});
        check({tag, ".minutes"}, {25'd0, minutes}, {25'd0, m});
        check({tag, ".seconds"}, {25'd0, seconds}, {25'd0, s});
    endtask

    // Each pulse task starts and ends on a falling edge; results are visible on return.
    task automatic pulse_1hz();
        clk_1hz = 1'b1;
        @(negedge clk);
        clk_1hz = 1'b0;
    endtask

    task automatic pulse_set();
        clk_set = 1'b1;
        @(negedge clk);
        clk_set = 1'b0;
    endtask

    task automatic pulse_both();
        clk_1hz = 1'b1;
        clk_set = 1'b1;
        @(negedge clk);
        clk_1hz = 1'b0;
        clk_set = 1'b0;
    endtask

    task automatic sync_wait();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts of set/1 Hz pulses (decimal) from the reset value to the wanted time.
    task automatic set_time(input int nh, input int nm, input int ns);
        do_reset();
        set_hours = 1'b1;
        sync_wait();
        for (int i = 0; i < nh; i++) begin
            pulse_set();
            @(negedge clk);
        end
        set_hours = 1'b0;
        sync_wait();
        set_minutes = 1'b1;
        sync_wait();
        for (int i = 0; i < nm; i++) begin
            pulse_set();
            @(negedge clk);
        end
        set_minutes = 1'b0;
        sync_wait();
        for (int i = 0; i < ns; i++) begin
            pulse_1hz();
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
`ifdef CLOCK_REGISTER_12HR_EN
        check_time("reset12", 6'h12, 7'h00, 7'h00);
        check("reset12.pm", {31'd0, pm}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        set_time(11, 59, 59);
        check_time("pre_noon", 6'h11, 7'h59, 7'h59);
        check("pre_noon.pm", {31'd0, pm}, 32'd0);
        pulse_1hz();
        check_time("noon", 6'h12, 7'h00, 7'h00);
        check("noon.pm", {31'd0, pm}, 32'd1);
        check("noon.tick", {31'd0, sec_tick}, 32'd1);
        @(negedge clk);

        set_minutes = 1'b1;
        sync_wait();
        for (int i = 0; i < 59; i++) begin
            pulse_set();
            @(negedge clk);
        end
        set_minutes = 1'b0;
        sync_wait();
        for (int i = 0; i < 59; i++) begin
            pulse_1hz();
            @(negedge clk);
        end
        check_time("pre_one", 6'h12, 7'h59, 7'h59);
        pulse_1hz();
        check_time("one", 6'h01, 7'h00, 7'h00);
        check("one.pm", {31'd0, pm}, 32'd1);
`else
        check_time("reset", 6'h00, 7'h00, 7'h00);
        check("reset.tick", {31'd0, sec_tick}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            pulse_1hz();
            @(negedge clk);
        end
        check_time("sec09", 6'h00, 7'h00, 7'h09);
        pulse_1hz();
        check_time("sec10", 6'h00, 7'h00, 7'h10);
        check("sec10.tick", {31'd0, sec_tick}, 32'd1);
        @(negedge clk);
        check("sec10.tick_off", {31'd0, sec_tick}, 32'd0);

        set_time(12, 34, 56);
        check_time("pre_reset", 6'h12, 7'h34, 7'h56);
        reset_n = 1'b0;
        #1;
        check_time("async_reset", 6'h00, 7'h00, 7'h00);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_time("after_reset", 6'h00, 7'h00, 7'h00);
        check("after_reset.tick", {31'd0, sec_tick}, 32'd0);

        set_time(23, 59, 59);
        check_time("pre_roll", 6'h23, 7'h59, 7'h59);
        pulse_1hz();
        check_time("roll", 6'h00, 7'h00, 7'h00);
        check("roll.tick", {31'd0, sec_tick}, 32'd1);
        @(negedge clk);
        check("roll.tick_off", {31'd0, sec_tick}, 32'd0);

        set_time(10, 59, 37);
        check_time("pre_setm", 6'h10, 7'h59, 7'h37);
        set_minutes = 1'b1;
        sync_wait();
        check("setm.sec_clr", {25'd0, seconds}, 32'h00);
        check("setm.entry_tick", {31'd0, sec_tick}, 32'd1);
        pulse_set();
        check_time("setm1", 6'h10, 7'h00, 7'h00);
        check("setm1.tick", {31'd0, sec_tick}, 32'd1);
        @(negedge clk);
        pulse_set();
        check_time("setm2", 6'h10, 7'h01, 7'h00);
        set_minutes = 1'b0;
        sync_wait();

        set_time(23, 58, 0);
        set_hours = 1'b1;
        set_minutes = 1'b1;
        sync_wait();
        check("setb.entry_tick", {31'd0, sec_tick}, 32'd0);
        pulse_set();
        check_time("setb1", 6'h00, 7'h59, 7'h00);
        @(negedge clk);
        pulse_1hz();
        check_time("setb_1hz", 6'h00, 7'h59, 7'h00);
        check("setb_1hz.tick", {31'd0, sec_tick}, 32'd0);
        @(negedge clk);
        pulse_set();
        check_time("setb2", 6'h01, 7'h00, 7'h00);
        set_hours = 1'b0;
        set_minutes = 1'b0;
        sync_wait();

        pulse_both();
        check_time("both_run", 6'h01, 7'h00, 7'h01);
        @(negedge clk);
        set_hours = 1'b1;
        sync_wait();
        check("both_set.sec_clr", {25'd0, seconds}, 32'h00);
        pulse_both();
        check_time("both_set", 6'h02, 7'h00, 7'h00);
        check("both_set.tick", {31'd0, sec_tick}, 32'd1);
        set_hours = 1'b0;
        sync_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_register.md
Name: clock_register

Overview:
- Time-of-day counter that sits directly downstream of clock_divider.
- Consumes the divider's clk_1hz and clk_set outputs, plus the user set buttons.
- Holds hours/minutes/seconds as packed BCD for the display driver.
- All logic runs in the single system clock domain; divider outputs are treated as level signals and edge-detected internally.

Parameters:
- SYNC_STAGES, 2, synchronizer flop depth applied to the asynchronous button inputs (min 2).

Ports:
- clk  in  1  system clock (12.5 kHz in the reference build)
- reset_n  in  1  asynchronous active-low reset
- clk_1hz  in  1  1 Hz level signal from clock_divider
- clk_set  in  1  fast set-rate level signal from clock_divider
- set_hours  in  1  async button, increment hours while held
- set_minutes  in  1  async button, increment minutes while held
- hours  out  6  BCD hours, [5:4] tens, [3:0] ones
- minutes  out  7  BCD minutes, [6:4] tens, [3:0] ones
- seconds  out  7  BCD seconds, [6:4] tens, [3:0] ones
- sec_tick  out  1  one-clk pulse whenever the time value changes

Behaviour:
- Reset (async assert, sync release): all outputs zero, i.e. 00:00:00 and sec_tick=0; edge-detect and synchronizer flops cleared.
- Button sync: set_hours/set_minutes pass through SYNC_STAGES flops; the synchronized values are sh and sm.
- Edge detect: each of clk_1hz and clk_set is registered once.
  - tick_1hz = clk_1hz & ~prev_1hz; tick_set likewise.
  - Counters update on the same clk edge on which the tick is combinationally high. Output latency is 1 clk after the input rising edge is sampled.
- Modes (decided combinationally each cycle):
  - RUN: sh=0 and sm=0.
  - SET: sh|sm=1.
- RUN on tick_1hz:
  - seconds +1, wrapping 59→00.
  - On wrap, minutes +1, wrapping 59→00.
  - On minutes wrap, hours +1, wrapping 23→00.
  - BCD ones digits wrap 9→0 with carry into the tens digit.
- SET:
  - seconds forced to 00 on the first SET cycle and held there; tick_1hz is ignored.
  - On tick_set: if sm, minutes +1 with 59→00 wrap and no carry into hours; if sh, hours +1 with 23→00 wrap.
  - sh and sm both high: both fields increment on the same tick.
- Simultaneous tick_1hz and tick_set: SET mode rules apply whenever sh|sm is high; otherwise tick_set is ignored.
- sec_tick: asserted for exactly one clk on any cycle where hours, minutes or seconds is written with a new value. It is also asserted on the SET entry cycle if seconds was nonzero.
- Reset mid-operation: immediate return to 00:00:00 regardless of mode. No partially updated field is possible, because all fields update on the same edge.
- Invalid BCD states cannot be reached. For robustness, any digit outside its range (e.g. ones>9) wraps to 0 on its next increment.

Optional Feature:
- Macro: CLOCK_REGISTER_12HR_EN.
- Defined:
  - hours counts 12,01..11, with reset value 12; an extra output pm (1 bit, reset 0) is added.
  - 11→12 toggles pm in RUN; it also toggles pm in SET when hours is incremented.
- Undefined: 24-hour behaviour as above; no pm port.

Decomposition:
- Package clock_pkg:
  - BCD digit width constants: 4 for ones, 3 for minute/second tens, 2 for hour tens.
  - Wrap limits: SEC_MAX=59, MIN_MAX=59, HR_MAX_24=23, HR_MAX_12=12.
  - Packed field widths 7/7/6.
- Sub-module bcd_counter:
  - Parameterized two-digit BCD counter with inc, clear and wrap-value inputs; outputs carry on wrap.
  - Instantiated for seconds, minutes and hours.

Test Plan:
- Reset: drive reset_n=0 mid-count at 12:34:56, release → outputs 00:00:00, sec_tick=0 for the next cycle.
- RUN rollover:
  - Preload by counting to 23:59:59, then one clk_1hz rising edge → 00:00:00, one sec_tick pulse.
  - Also 00:00:09→00:00:10 (digit carry).
- SET minutes: hold set_minutes at 10:59:37, then 2 clk_set edges → seconds 00 immediately, minutes 00 then 01, hours stays 10.
- SET both: hold both buttons at 23:58:00, then 2 clk_set edges → 00:59 then 01:00. clk_1hz edges during the hold leave seconds at 00.
- Simultaneity: clk_1hz and clk_set rise on the same clk with no button held → only seconds +1. Repeat with set_hours held → only hours +1, seconds 00.
- 12HR (macro defined): from 11:59:59, pm=0, one 1 Hz edge → 12:00:00, pm=1; from 12:59:59 → 01:00:00, pm unchanged.
